// File: rtl/uart_line_buffer.sv
// Line assembler between uart_rx and uart_tx: gathers bytes with backspace editing
// and releases a complete line (terminator or full buffer) as one burst.
module uart_line_buffer #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] TERM_CHAR = 8'h0D,
    parameter bit         BS_EDIT   = 1'b1
) (
    input  logic       axis_aclk,
    input  logic       axis_aresetn,
    input  logic       s_axis_tvalid,
    input  logic [7:0] s_axis_tdata,
    output logic       s_axis_tready,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    input  logic       m_axis_tready,
    output logic       line_overflow,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rdy_q;
    logic          ovf_q, ovf_d;
    logic [7:0]    tdata_q, tdata_d;
    logic [7:0]    mem_q [DEPTH];

    logic          s_fire, m_fire, is_term, is_bs, mem_we;
    logic [AW-1:0] wr_addr;

    assign s_axis_tready = rdy_q;
    assign m_axis_tvalid = (state_q == ST_DRAIN);
    assign m_axis_tdata  = tdata_q;
    assign line_overflow = ovf_q;
    assign busy          = (state_q == ST_DRAIN);

    assign s_fire  = s_axis_tvalid && rdy_q;
    assign m_fire  = m_axis_tvalid && m_axis_tready;
    assign is_term = (s_axis_tdata == TERM_CHAR);
    assign is_bs   = BS_EDIT && !is_term &&
                     ((s_axis_tdata == 8'h08) || (s_axis_tdata == 8'h7F));
    assign mem_we  = s_fire && !is_bs;
    assign wr_addr = wr_cnt_q[AW-1:0];

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = 1'b0;
        tdata_d  = tdata_q;
        case (state_q)
            ST_FILL: begin
                if (s_fire) begin
                    if (is_term) begin
                        len_d    = wr_cnt_q + CW'(1);
                        rd_ptr_d = '0;
                        state_d  = ST_DRAIN;
                    end else if (is_bs) begin
                        if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - CW'(1);
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                        if (wr_cnt_q + CW'(1) == CW'(DEPTH)) begin
                            len_d    = CW'(DEPTH);
                            rd_ptr_d = '0;
                            ovf_d    = 1'b1;
                            state_d  = ST_DRAIN;
                        end
                    end
                end
            end
            default: begin
                if (m_fire) begin
                    if ({1'b0, rd_ptr_q} == len_q - CW'(1)) begin
                        state_d  = ST_FILL;
                        wr_cnt_d = '0;
                        rd_ptr_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
        endcase
        // Entry into DRAIN can coincide with writing byte 0 (a bare terminator line).
        if (state_d == ST_DRAIN) begin
            tdata_d = (mem_we && (wr_addr == rd_ptr_d)) ? s_axis_tdata : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q  <= ST_FILL;
            wr_cnt_q <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
            ovf_q    <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= (state_d == ST_FILL);
            ovf_q    <= ovf_d;
            tdata_q  <= tdata_d;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (mem_we) mem_q[wr_addr] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: a DEPTH=256 and a DEPTH=4 instance driven against a
// queue-based line model, with directed cases and randomized byte streams.
module tb_uart_line_buffer;

    logic       clk;
    logic       rst_n;
    logic       s_vld [2];
    logic [7:0] s_dat [2];
    logic       s_rdy [2];
    logic       m_vld [2];
    logic [7:0] m_dat [2];
    logic       m_rdy;
    logic       ovf   [2];
    logic       bsy   [2];

    int errors = 0;
    int checks = 0;
    int cur = 0;
    int depth_cur = 256;
    int bp_mode = 0;
    int ovf_got = 0;
    int ovf_exp = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_dat = 8'h00;

    logic [7:0] model_line [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] seq [$];

    uart_line_buffer #(.DEPTH(256)) u_big (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld[0]), .s_axis_tdata(s_dat[0]), .s_axis_tready(s_rdy[0]),
        .m_axis_tvalid(m_vld[0]), .m_axis_tdata(m_dat[0]), .m_axis_tready(m_rdy),
        .line_overflow(ovf[0]), .busy(bsy[0])
    );

    uart_line_buffer #(.DEPTH(4)) u_small (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s_axis_tvalid(s_vld[1]), .s_axis_tdata(s_dat[1]), .s_axis_tready(s_rdy[1]),
        .m_axis_tvalid(m_vld[1]), .m_axis_tdata(m_dat[1]), .m_axis_tready(m_rdy),
        .line_overflow(ovf[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
            $error("check %s failed", tag);
        end
    endtask

    // Line model: edit a byte list, emit it on terminator or when it reaches DEPTH.
    task automatic model_push(input logic [7:0] b);
        if (b == 8'h0D) begin
            model_line.push_back(b);
            foreach (model_line[i]) exp_q.push_back(model_line[i]);
            model_line.delete();
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (model_line.size() > 0) void'(model_line.pop_back());
        end else begin
            model_line.push_back(b);
            if (model_line.size() == depth_cur) begin
                foreach (model_line[i]) exp_q.push_back(model_line[i]);
                model_line.delete();
                ovf_exp++;
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       m_rdy = 1'b1;
            1:       m_rdy = 1'($urandom_range(0, 1));
            default: m_rdy = 1'b0;
        endcase
    end

    // Monitor at the falling edge: a handshake seen here completes on the next rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_vld[cur] && m_rdy) got_q.push_back(m_dat[cur]);
            if (ovf[cur]) ovf_got++;
            if (stall_prev) begin
                chk("stall_vld", 32'(m_vld[cur]), 32'd1);
                chk("stall_data", 32'(m_dat[cur]), 32'(stall_dat));
            end
            chk("s_m_exclusive", 32'(s_rdy[cur] && m_vld[cur]), 32'd0);
            stall_prev = m_vld[cur] && !m_rdy;
            stall_dat  = m_dat[cur];
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        model_push(b);
        s_vld[cur] = 1'b1;
        s_dat[cur] = b;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (s_rdy[cur]) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("s_ready_timeout", 32'd0, 32'd1);
        s_vld[cur] = 1'b0;
        s_dat[cur] = 8'($urandom);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic drain_and_compare(input string tag);
        bit done = 0;
        for (int n = 0; n < 5000 && !done; n++) begin
            if (!m_vld[cur] && got_q.size() >= exp_q.size()) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk({tag, "_drain_timeout"}, 32'd0, 32'd1);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_overflow_pulses"}, 32'(ovf_got), 32'(ovf_exp));
        got_q.delete();
        exp_q.delete();
        ovf_got = 0;
        ovf_exp = 0;
    endtask

    task automatic select_dut(input int sel);
        cur = sel;
        depth_cur = (sel == 0) ? 256 : 4;
        model_line.delete();
    endtask

    function automatic logic [7:0] rand_byte();
        int r = int'($urandom_range(0, 99));
        if (r < 8) return 8'h0D;
        if (r < 16) return (r[0]) ? 8'h08 : 8'h7F;
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    initial begin
        rst_n = 1'b1;
        m_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_vld[i] = 1'b0;
            s_dat[i] = 8'h00;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_s_ready", 32'(s_rdy[i]), 32'd0);
            chk("rst_m_valid", 32'(m_vld[i]), 32'd0);
            chk("rst_m_data", 32'(m_dat[i]), 32'd0);
            chk("rst_overflow", 32'(ovf[i]), 32'd0);
            chk("rst_busy", 32'(bsy[i]), 32'd0);
        end
        rst_n = 1'b1;
        #1 chk("rel_s_ready_still_low", 32'(s_rdy[0]), 32'd0);
        @(posedge clk);
        #1 chk("rel_s_ready_first_edge", 32'(s_rdy[0]), 32'd1);

        // Basic line with full-rate sink
        select_dut(0);
        bp_mode = 0;
        seq = '{8'h41, 8'h42, 8'h0D};
        send_seq();
        chk("t1_s_ready_low", 32'(s_rdy[0]), 32'd0);
        chk("t1_m_valid", 32'(m_vld[0]), 32'd1);
        chk("t1_busy", 32'(bsy[0]), 32'd1);
        chk("t1_first_data", 32'(m_dat[0]), 32'h41);
        drain_and_compare("t1");
        chk("t1_s_ready_back", 32'(s_rdy[0]), 32'd1);
        chk("t1_busy_clear", 32'(bsy[0]), 32'd0);

        // Backspace editing
        seq = '{8'h41, 8'h42, 8'h08, 8'h43, 8'h0D};
        send_seq();
        drain_and_compare("t2a");
        seq = '{8'h08, 8'h0D};
        send_seq();
        drain_and_compare("t2b");

        // Small buffer: overflow flush, then terminator exactly at DEPTH
        select_dut(1);
        seq = '{8'h31, 8'h32, 8'h33, 8'h34};
        send_seq();
        drain_and_compare("t3a");
        seq = '{8'h0D};
        send_seq();
        drain_and_compare("t3b");
        seq = '{8'h31, 8'h32, 8'h33, 8'h0D};
        send_seq();
        drain_and_compare("t4");

        // Backpressure on the transmit side
        select_dut(0);
        bp_mode = 1;
        seq = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
        send_seq();
        drain_and_compare("t5");

        // Randomized streams on both depths
        for (int i = 0; i < 150; i++) send_byte(rand_byte());
        send_byte(8'h0D);
        drain_and_compare("rnd_big");
        select_dut(1);
        for (int i = 0; i < 80; i++) send_byte(rand_byte());
        send_byte(8'h0D);
        drain_and_compare("rnd_small");

        // Reset while a line is waiting to drain
        select_dut(0);
        bp_mode = 2;
        @(posedge clk);
        #1;
        seq = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D};
        send_seq();
        repeat (3) @(posedge clk);
        #1 chk("t6_stalled_valid", 32'(m_vld[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", 32'(m_vld[0]), 32'd0);
        chk("t6_rst_busy", 32'(bsy[0]), 32'd0);
        chk("t6_rst_s_ready", 32'(s_rdy[0]), 32'd0);
        chk("t6_rst_m_data", 32'(m_dat[0]), 32'd0);
        got_q.delete();
        exp_q.delete();
        model_line.delete();
        ovf_got = 0;
        ovf_exp = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bp_mode = 0;
        @(posedge clk);
        #1;
        seq = '{8'h58, 8'h0D};
        send_seq();
        drain_and_compare("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
